// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-port data DRAM: CPU MEM stage (port 0)
// has priority, the loader/DMA engine (port 1) is protected from starvation,
// and a lock keeps read-modify-write sequences atomic. Read data returns one
// cycle after issue.
module dmem_arbiter #(
  parameter int unsigned AW         = 32,
  parameter int unsigned DW         = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid,
  input  logic          req0_we,
  input  logic          req0_lock,
  input  logic [AW-1:0] req0_adr,
  input  logic [DW-1:0] req0_wdata,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic          req1_we,
  input  logic          req1_lock,
  input  logic [AW-1:0] req1_adr,
  input  logic [DW-1:0] req1_wdata,
  output logic          req1_ready,
  output logic          rsp0_valid,
  output logic [DW-1:0] rsp0_rdata,
  output logic          rsp1_valid,
  output logic [DW-1:0] rsp1_rdata,
  output logic          dram_en,
  output logic          dram_we,
  output logic [AW-1:0] dram_adr,
  output logic [DW-1:0] dram_wdin,
  input  logic [DW-1:0] dram_rd
);

  localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    LOCK0    = 2'd1,
    LOCK1    = 2'd2
  } lock_e;

  lock_e      lock_q;
  logic [7:0] starve_cnt;
  logic [1:0] rsp_vld;
  logic [1:0] rsp_rd;
  logic       gnt0_c;
  logic       gnt1_c;

  // Grant selection; held off entirely while reset is asserted
  always_comb begin
    gnt0_c = 1'b0;
    gnt1_c = 1'b0;
    if (!rst) begin
      unique case (lock_q)
        UNLOCKED: begin
          if (req1_valid && (starve_cnt == STARVE_LIM)) gnt1_c = 1'b1;
          else if (req0_valid)                          gnt0_c = 1'b1;
          else if (req1_valid)                          gnt1_c = 1'b1;
        end
        LOCK0:   gnt0_c = req0_valid;
        LOCK1:   gnt1_c = req1_valid;
        default: ;
      endcase
    end
  end

  assign req0_ready = gnt0_c;
  assign req1_ready = gnt1_c;

  // DRAM command mux from the granted port, all zero when idle
  always_comb begin
    dram_en   = 1'b0;
    dram_we   = 1'b0;
    dram_adr  = '0;
    dram_wdin = '0;
    if (gnt0_c) begin
      dram_en   = 1'b1;
      dram_we   = req0_we;
      dram_adr  = req0_adr;
      dram_wdin = req0_wdata;
    end else if (gnt1_c) begin
      dram_en   = 1'b1;
      dram_we   = req1_we;
      dram_adr  = req1_adr;
      dram_wdin = req1_wdata;
    end
  end

  // Lock FSM: an accepted request's lock bit decides whether its port keeps the grant
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_q <= UNLOCKED;
    end else if (gnt0_c) begin
      lock_q <= req0_lock ? LOCK0 : UNLOCKED;
    end else if (gnt1_c) begin
      lock_q <= req1_lock ? LOCK1 : UNLOCKED;
    end
  end

  // Port 1 starvation counter, saturating at the override threshold
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= 8'd0;
    end else if (!req1_valid || gnt1_c) begin
      starve_cnt <= 8'd0;
    end else if (starve_cnt != STARVE_LIM) begin
      starve_cnt <= starve_cnt + 8'd1;
    end
  end

  // Response tracking: one-cycle delayed issue record per port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_vld <= 2'b00;
      rsp_rd  <= 2'b00;
    end else begin
      rsp_vld <= {gnt1_c, gnt0_c};
      rsp_rd  <= {gnt1_c & ~req1_we, gnt0_c & ~req0_we};
    end
  end

  assign rsp0_valid = rsp_vld[0];
  assign rsp1_valid = rsp_vld[1];
  assign rsp0_rdata = rsp_rd[0] ? dram_rd : '0;
  assign rsp1_rdata = rsp_rd[1] ? dram_rd : '0;

endmodule
